// File: rtl/btb_pkg.sv
// ---------------------------------------------------------------------------
// btb_pkg
// Shared definitions for the set-associative branch target buffer:
//   - cnt_e      : 2-bit direction counter encodings (SNT/WNT/WT/ST)
//   - CNT_RESET  : counter value loaded on reset
//   - cnt_op_e   : operations understood by btb_sat_counter
//   - helpers    : tag and way-index width calculations
// ---------------------------------------------------------------------------
package btb_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_e;

    localparam cnt_e CNT_RESET = CNT_WNT;

    typedef enum logic [1:0] {
        CNT_OP_HOLD   = 2'd0,
        CNT_OP_INC    = 2'd1,
        CNT_OP_DEC    = 2'd2,
        CNT_OP_SET_ST = 2'd3
    } cnt_op_e;

    // Number of tag bits left above the index and alignment fields.
    function automatic int btb_tag_width(input int addr_w, input int align_bits, input int index_bits);
        return addr_w - align_bits - index_bits;
    endfunction

    // Width of a way number / victim pointer; at least one bit so WAYS=1 still elaborates.
    function automatic int btb_way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// ---------------------------------------------------------------------------
// btb_sat_counter
// Combinational next-state for a 2-bit saturating direction counter.
// Ports:
//   cnt      in  2  current counter value
//   op       in  2  hold / increment / decrement / set strongly-taken
//   cnt_next out 2  next counter value (saturates at 0 and 3)
// ---------------------------------------------------------------------------
module btb_sat_counter
    import btb_pkg::*;
(
    input  logic [1:0] cnt,
    input  cnt_op_e    op,
    output logic [1:0] cnt_next
);

    // Saturating next-state selection.
    always_comb begin
        cnt_next = cnt;
        case (op)
            CNT_OP_INC: begin
                if (cnt != CNT_ST) begin
                    cnt_next = cnt + 2'd1;
                end else begin
                    cnt_next = cnt;
                end
            end
            CNT_OP_DEC: begin
                if (cnt != CNT_SNT) begin
                    cnt_next = cnt - 2'd1;
                end else begin
                    cnt_next = cnt;
                end
            end
            CNT_OP_SET_ST: cnt_next = CNT_ST;
            CNT_OP_HOLD:   cnt_next = cnt;
            default:       cnt_next = cnt;
        endcase
    end

endmodule

// File: rtl/btb_set_assoc.sv
// ---------------------------------------------------------------------------
// btb_set_assoc
// Set-associative branch target buffer with full tags, per-entry target and
// 2-bit direction counter, and a per-set round-robin victim pointer.
// Optional feature macro: BTB_BYPASS_EN -- forward a same-cycle update to a
// lookup of the same entry (index and tag equal). Default: no forwarding.
// Ports:
//   clk           in   1       rising-edge clock
//   arst_n        in   1       asynchronous active-low reset
//   en            in   1       global enable (low: no lookup/update, outputs hold)
//   lookup_pc     in   ADDR_W  fetch PC to predict
//   hit           out  1       registered: previous lookup hit a taken-predicting entry
//   predicted_pc  out  ADDR_W  registered target when hit, else 0
//   upd_valid     in   1       resolved control-flow instruction present
//   upd_pc        in   ADDR_W  PC of resolved instruction
//   upd_target    in   ADDR_W  resolved target
//   upd_taken     in   1       conditional branch taken
//   upd_jump      in   1       unconditional jump (implies taken)
// ---------------------------------------------------------------------------
module btb_set_assoc
    import btb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int INDEX_BITS = 3,
    parameter int WAYS       = 2,
    parameter int ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              hit,
    output logic [ADDR_W-1:0] predicted_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              upd_jump
);

    localparam int SETS    = 2 ** INDEX_BITS;
    localparam int TAG_W   = btb_tag_width(ADDR_W, ALIGN_BITS, INDEX_BITS);
    localparam int WAY_W   = btb_way_width(WAYS);
    localparam int TAG_LSB = ALIGN_BITS + INDEX_BITS;

    // Table storage, all flops.
    logic              valid_r  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_r    [SETS][WAYS];
    logic [ADDR_W-1:0] target_r [SETS][WAYS];
    logic [1:0]        cnt_r    [SETS][WAYS];
    logic [WAY_W-1:0]  victim_r [SETS];

    logic              hit_r;
    logic [ADDR_W-1:0] predicted_pc_r;

    // Field extraction.
    logic [INDEX_BITS-1:0] lk_idx_s;
    logic [INDEX_BITS-1:0] up_idx_s;
    logic [TAG_W-1:0]      lk_tag_s;
    logic [TAG_W-1:0]      up_tag_s;
    logic                  unused_align_s;

    assign lk_idx_s = lookup_pc[TAG_LSB-1:ALIGN_BITS];
    assign up_idx_s = upd_pc[TAG_LSB-1:ALIGN_BITS];
    assign lk_tag_s = lookup_pc[ADDR_W-1:TAG_LSB];
    assign up_tag_s = upd_pc[ADDR_W-1:TAG_LSB];
    assign unused_align_s = ^{lookup_pc[ALIGN_BITS-1:0], upd_pc[ALIGN_BITS-1:0]};

    // Lookup-side match: lowest valid way with equal tag wins.
    logic             lk_match_s;
    logic [WAY_W-1:0] lk_way_s;

    // Lookup tag compare across the indexed set.
    always_comb begin
        lk_match_s = 1'b0;
        lk_way_s   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_r[lk_idx_s][w] && (tag_r[lk_idx_s][w] == lk_tag_s)) begin
                lk_match_s = 1'b1;
                lk_way_s   = WAY_W'(w);
            end else begin
                lk_match_s = lk_match_s;
            end
        end
    end

    // Update-side tag hit and lowest free way in the update set.
    logic             up_hit_s;
    logic [WAY_W-1:0] up_hit_way_s;
    logic             up_free_s;
    logic [WAY_W-1:0] up_free_way_s;

    // Update tag compare and free-way search; descending loop makes the lowest way win.
    always_comb begin
        up_hit_s      = 1'b0;
        up_hit_way_s  = '0;
        up_free_s     = 1'b0;
        up_free_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_r[up_idx_s][w] && (tag_r[up_idx_s][w] == up_tag_s)) begin
                up_hit_s     = 1'b1;
                up_hit_way_s = WAY_W'(w);
            end else begin
                up_hit_s = up_hit_s;
            end
            if (!valid_r[up_idx_s][w]) begin
                up_free_s     = 1'b1;
                up_free_way_s = WAY_W'(w);
            end else begin
                up_free_s = up_free_s;
            end
        end
    end

    // Write decision for this cycle.
    logic             up_taken_s;
    logic             wr_en_s;
    logic             wr_tgt_en_s;
    logic             alloc_s;
    logic             adv_ptr_s;
    logic [WAY_W-1:0] wr_way_s;
    cnt_op_e          cnt_op_s;
    logic [1:0]       cnt_cur_s;
    logic [1:0]       cnt_upd_s;
    logic [1:0]       wr_cnt_s;
    logic [WAY_W-1:0] victim_next_s;

    // A jump with taken=0 still counts as taken.
    assign up_taken_s = upd_taken | upd_jump;
    assign cnt_cur_s  = cnt_r[up_idx_s][up_hit_way_s];

    // Select write way, target enable and counter operation.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_tgt_en_s = 1'b0;
        alloc_s     = 1'b0;
        adv_ptr_s   = 1'b0;
        wr_way_s    = '0;
        cnt_op_s    = CNT_OP_HOLD;
        if (en && upd_valid) begin
            if (up_hit_s) begin
                wr_en_s     = 1'b1;
                wr_way_s    = up_hit_way_s;
                wr_tgt_en_s = up_taken_s;
                if (upd_jump) begin
                    cnt_op_s = CNT_OP_SET_ST;
                end else if (upd_taken) begin
                    cnt_op_s = CNT_OP_INC;
                end else begin
                    cnt_op_s = CNT_OP_DEC;
                end
            end else if (up_taken_s) begin
                wr_en_s     = 1'b1;
                wr_tgt_en_s = 1'b1;
                alloc_s     = 1'b1;
                if (up_free_s) begin
                    wr_way_s = up_free_way_s;
                end else begin
                    wr_way_s  = victim_r[up_idx_s];
                    adv_ptr_s = 1'b1;
                end
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    btb_sat_counter u_upd_cnt (
        .cnt      (cnt_cur_s),
        .op       (cnt_op_s),
        .cnt_next (cnt_upd_s)
    );

    // New allocations start weakly taken, or strongly taken for a jump.
    assign wr_cnt_s = alloc_s ? (upd_jump ? CNT_ST : CNT_WT) : cnt_upd_s;

    // Round-robin advance; wraps at WAYS so non-power-of-two associativity works.
    assign victim_next_s = (victim_r[up_idx_s] == WAY_W'(WAYS - 1)) ? '0
                                                                    : victim_r[up_idx_s] + WAY_W'(1);

    // Lookup result, optionally forwarded from the same-cycle update.
    logic              res_hit_s;
    logic [ADDR_W-1:0] res_tgt_s;

`ifdef BTB_BYPASS_EN
    logic byp_s;

    // Use the post-update entry when the update hits the looked-up entry.
    always_comb begin
        byp_s = wr_en_s && (lk_idx_s == up_idx_s) && (lk_tag_s == up_tag_s);
        if (byp_s) begin
            res_hit_s = wr_cnt_s[1];
            res_tgt_s = wr_tgt_en_s ? upd_target : target_r[up_idx_s][wr_way_s];
        end else begin
            res_hit_s = lk_match_s & cnt_r[lk_idx_s][lk_way_s][1];
            res_tgt_s = target_r[lk_idx_s][lk_way_s];
        end
    end
`else
    assign res_hit_s = lk_match_s & cnt_r[lk_idx_s][lk_way_s][1];
    assign res_tgt_s = target_r[lk_idx_s][lk_way_s];
`endif

    // Table state: reset clears everything; otherwise commit the selected write.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int s = 0; s < SETS; s++) begin
                victim_r[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w]  <= 1'b0;
                    tag_r[s][w]    <= '0;
                    target_r[s][w] <= '0;
                    cnt_r[s][w]    <= CNT_RESET;
                end
            end
        end else if (wr_en_s) begin
            valid_r[up_idx_s][wr_way_s] <= 1'b1;
            tag_r[up_idx_s][wr_way_s]   <= up_tag_s;
            cnt_r[up_idx_s][wr_way_s]   <= wr_cnt_s;
            if (wr_tgt_en_s) begin
                target_r[up_idx_s][wr_way_s] <= upd_target;
            end else begin
                target_r[up_idx_s][wr_way_s] <= target_r[up_idx_s][wr_way_s];
            end
            if (adv_ptr_s) begin
                victim_r[up_idx_s] <= victim_next_s;
            end else begin
                victim_r[up_idx_s] <= victim_r[up_idx_s];
            end
        end else begin
            victim_r[0] <= victim_r[0];
        end
    end

    // Registered prediction outputs; hold while disabled.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            hit_r          <= 1'b0;
            predicted_pc_r <= '0;
        end else if (en) begin
            hit_r          <= res_hit_s;
            predicted_pc_r <= res_hit_s ? res_tgt_s : '0;
        end else begin
            hit_r          <= hit_r;
            predicted_pc_r <= predicted_pc_r;
        end
    end

    assign hit          = hit_r;
    assign predicted_pc = predicted_pc_r;

endmodule

// File: doc/btb_set_assoc.md
# btb_set_assoc

Parametrised set-associative branch target buffer, the successor to the direct-mapped single-table predictor in the fetch stage. Each entry stores a full tag, a target address and a 2-bit saturating direction counter. A lookup on the fetch PC returns a registered hit/target one cycle later. Resolved branches and jumps from execute update the table, and replacement within a set uses a per-set round-robin victim pointer.

## Interface
- `ADDR_W`, default 64: PC and target width.
- `INDEX_BITS`, default 3: set index width; `SETS = 2**INDEX_BITS`.
- `WAYS`, default 2: associativity, 1..8.
- `ALIGN_BITS`, default 2: low PC bits ignored (word-aligned instructions).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `arst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  global enable; when low, no lookup, no update, outputs hold.
- `lookup_pc`  in  ADDR_W  fetch PC to predict.
- `hit`  out  1  registered: previous lookup matched a valid entry predicting taken.
- `predicted_pc`  out  ADDR_W  registered target when `hit`=1, else 0.
- `upd_valid`  in  1  resolved control-flow instruction present this cycle.
- `upd_pc`  in  ADDR_W  PC of the resolved instruction.
- `upd_target`  in  ADDR_W  resolved target address.
- `upd_taken`  in  1  conditional branch was taken.
- `upd_jump`  in  1  instruction is an unconditional jump (implies taken).

## Operation
- **Index:** `pc[ALIGN_BITS+INDEX_BITS-1 : ALIGN_BITS]`.
- **Tag:** `pc[ADDR_W-1 : ALIGN_BITS+INDEX_BITS]`. Full tag, no aliasing.
- **Lookup:** compare all ways of the indexed set. Lookup hit means valid, tag equal and counter[1]=1.
  - More than one matching way cannot occur by construction.
  - If it does, the lowest way wins.
- **Update on a tag hit in way w:**
  - `upd_jump` → counter=3, target←upd_target.
  - `upd_taken` → counter saturating +1, target←upd_target.
  - otherwise → counter saturating −1; entry stays valid.
- **Update on a tag miss:**
  - taken or jump → allocate.
    - Victim is the lowest invalid way. If every way is valid, the victim is the way at the set's victim pointer, and that pointer then advances modulo WAYS.
    - Write valid=1, tag, target; counter=3 if jump, else 2.
  - not-taken miss → no change.
- `upd_jump` together with `upd_taken`=0 is treated as a jump.

## Timing
- **Reset (async, any time, including mid-update):**
  - all valid=0, counters=2'b01, victim pointers=0;
  - `hit`=0, `predicted_pc`=0;
  - takes effect immediately, with no partial write committed.
- **Lookup latency:** 1 cycle. `lookup_pc` sampled at edge N → `hit`/`predicted_pc` valid after edge N.
- **Update latency:** table written at the edge where `upd_valid`=1 and `en`=1. Visible to lookups sampled at the next edge.
- **Same-cycle lookup and update to the same entry:** without bypass, the lookup sees the pre-update table (see Configuration).
- **`en`=0:** outputs and table hold; `upd_valid` is ignored (dropped, not queued).
- **WAYS=1:** victim pointer is unused; a taken miss always replaces way 0.

## Configuration
- **`BTB_BYPASS_EN` defined:** when `upd_valid` and `lookup_pc` have equal index and tag in the same cycle, the lookup result uses the post-update entry state. This includes a fresh allocation and a counter crossing 2.
- **`BTB_BYPASS_EN` undefined:** no forwarding; the lookup uses stored state only.

## Structure
- **Shared package `btb_pkg`:**
  - counter encodings: `CNT_SNT`=0, `CNT_WNT`=1, `CNT_WT`=2, `CNT_ST`=3;
  - `CNT_RESET` = `CNT_WNT`;
  - index/tag width helper functions.
- **Sub-module `btb_sat_counter`:** 2-bit saturating inc/dec/set-strong, combinational next-state. Instantiated per update path.
- **Storage:** per-set arrays of valid, tag, target and counter indexed by way. Flops only, no SRAM macro.

## Test plan
- **Reset:** assert `arst_n`=0 mid-cycle, then release; lookup 0x1000 → `hit`=0, `predicted_pc`=0.
- **Allocate:** update pc=0x1000, target=0x2000, taken → next-cycle lookup 0x1000 gives `hit`=1, `predicted_pc`=0x2000. Lookup 0x1004 gives `hit`=0.
- **Counter hysteresis:** two not-taken updates on 0x1000 bring the counter 2→1→0, so lookup gives `hit`=0 after the first. Then one taken update (0→1) still gives `hit`=0, and a second taken update gives `hit`=1.
- **Replacement (WAYS=2, INDEX_BITS=3):**
  - taken updates at 0x1000, 0x2000 and 0x3000 map to set 0 with distinct tags;
  - 0x3000 evicts way 0, so 0x1000 misses;
  - 0x2000 and 0x3000 both hit with correct targets.
- **Jump:** update pc=0x4000, target=0x8000, `upd_jump`=1 → counter=3. One not-taken update follows → still `hit`=1.
- **Same-cycle hazard:** lookup 0x5000 in the same cycle as a taken update to 0x5000.
  - With `BTB_BYPASS_EN`: `hit`=1 next cycle.
  - Without it: `hit`=0, then `hit`=1 on a repeat lookup.
